// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser.
// Holds the frame FSM state encoding, the error code values reported on
// o_Err_Code, and the default frame start marker.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream / command-frame bundle between the UART receiver side and the
// acquisition core.
//   i_Rx_DV, i_Rx_Byte : received byte and its one-cycle valid strobe
//   o_Cmd_DV           : one-cycle strobe, good frame decoded
//   o_Cmd, o_Len       : command and payload length of the last good frame
//   o_Payload          : payload, byte k at [8k+7:8k], unused bytes 0
//   o_Err, o_Err_Code  : one-cycle drop strobe and held error code
//   o_Busy             : parser is inside a frame
// The master modport drives bytes in; the slave modport is the parser.
interface uart_cmd_parser_if #(
  parameter int MAX_LEN = 8
);

  logic                   i_Rx_DV;
  logic [7:0]             i_Rx_Byte;
  logic                   o_Cmd_DV;
  logic [7:0]             o_Cmd;
  logic [7:0]             o_Len;
  logic [8*MAX_LEN-1:0]   o_Payload;
  logic                   o_Err;
  logic [1:0]             o_Err_Code;
  logic                   o_Busy;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Cmd_DV, o_Cmd, o_Len, o_Payload, o_Err, o_Err_Code, o_Busy
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Cmd_DV, o_Cmd, o_Len, o_Payload, o_Err, o_Err_Code, o_Busy
  );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter for the command parser.
//   i_Clock, i_Rst_L : clock, asynchronous active-low reset
//   i_Clr            : clear the count (byte received, or parser idle)
//   i_En             : count this cycle (parser inside a frame)
//   o_Expire         : count has reached TIMEOUT_CLKS-1 while enabled
module uart_cmd_timeout #(
  parameter  int TIMEOUT_CLKS = 2160,
  localparam int CNT_W        = $clog2(TIMEOUT_CLKS + 1)
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Expire
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at the expiry value so a stalled count never wraps around.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt <= '0;
    end else if (i_Clr) begin
      cnt <= '0;
    end else if (i_En && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_Expire = i_En && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command frame parser.
// Frame: SYNC, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN, payload).
// Good frames update the held command outputs with a one-cycle o_Cmd_DV;
// oversize, bad-checksum and stalled frames are dropped with a one-cycle
// o_Err and a held error code.
//   i_Clock : system clock
//   i_Rst_L : asynchronous active-low reset
//   bus     : uart_cmd_parser_if slave (byte input, frame outputs)
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 2160,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  uart_cmd_parser_if.slave     bus
);

  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_t               state;
  logic [7:0]           cmd_stg;
  logic [7:0]           len_stg;
  logic [8*MAX_LEN-1:0] pay_stg;
  logic [7:0]           xor_acc;
  logic [7:0]           idx;
  logic [7:0]           rx_byte;
  logic                 tmo_expire;

  assign rx_byte = bus.i_Rx_Byte;

  uart_cmd_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock  (i_Clock),
    .i_Rst_L  (i_Rst_L),
    .i_Clr    (bus.i_Rx_DV || (state == S_SYNC)),
    .i_En     (state != S_SYNC),
    .o_Expire (tmo_expire)
  );

  assign bus.o_Busy = (state != S_SYNC);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state          <= S_SYNC;
      cmd_stg        <= '0;
      len_stg        <= '0;
      pay_stg        <= '0;
      xor_acc        <= '0;
      idx            <= '0;
      bus.o_Cmd_DV   <= 1'b0;
      bus.o_Cmd      <= '0;
      bus.o_Len      <= '0;
      bus.o_Payload  <= '0;
      bus.o_Err      <= 1'b0;
      bus.o_Err_Code <= ERR_NONE;
    end else begin
      bus.o_Cmd_DV <= 1'b0;
      bus.o_Err    <= 1'b0;
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (bus.i_Rx_DV) begin
        case (state)
          S_SYNC: begin
            if (rx_byte == SYNC_BYTE) state <= S_CMD;
          end
          S_CMD: begin
            cmd_stg <= rx_byte;
            xor_acc <= rx_byte;
            state   <= S_LEN;
          end
          S_LEN: begin
            if (rx_byte > LEN_MAX) begin
              bus.o_Err      <= 1'b1;
              bus.o_Err_Code <= ERR_LEN;
              state          <= S_SYNC;
            end else begin
              len_stg <= rx_byte;
              xor_acc <= xor_acc ^ rx_byte;
              idx     <= '0;
              pay_stg <= '0;
              state   <= (rx_byte == 8'd0) ? S_CHK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            for (int k = 0; k < MAX_LEN; k++) begin
              if (idx == 8'(k)) pay_stg[8*k +: 8] <= rx_byte;
            end
            xor_acc <= xor_acc ^ rx_byte;
            idx     <= idx + 8'd1;
            if (idx == len_stg - 8'd1) state <= S_CHK;
          end
          S_CHK: begin
            if (rx_byte == xor_acc) begin
              bus.o_Cmd     <= cmd_stg;
              bus.o_Len     <= len_stg;
              bus.o_Payload <= pay_stg;
              bus.o_Cmd_DV  <= 1'b1;
            end else begin
              bus.o_Err      <= 1'b1;
              bus.o_Err_Code <= ERR_CHK;
            end
            state <= S_SYNC;
          end
          default: state <= S_SYNC;
        endcase
      end else if (tmo_expire) begin
        bus.o_Err      <= 1'b1;
        bus.o_Err_Code <= ERR_TMO;
        state          <= S_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frame table, hand-written timeout and
// reset sequences, and random frames checked every cycle against a
// frame-level reference model.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int ML  = 8;
  localparam int TMO = 2160;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.MAX_LEN(ML)) bus ();

  uart_cmd_parser #(
    .MAX_LEN      (ML),
    .TIMEOUT_CLKS (TMO),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the frame collected so far, plus held outputs.
  logic [7:0]  fq[$];
  int          idle;
  logic        exp_dv, exp_err;
  logic [1:0]  exp_code;
  logic [7:0]  exp_cmd, exp_len;
  logic [63:0] exp_pay;
  logic        seen_dv, seen_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    idle = 0;
    exp_dv = 0; exp_err = 0; exp_code = 0;
    exp_cmd = 0; exp_len = 0; exp_pay = 0;
  endtask

  task automatic model_err(input logic [1:0] code);
    exp_err  = 1'b1;
    exp_code = code;
    fq.delete();
  endtask

  // One clock of the frame rules: bytes accumulate in fq until the frame is
  // complete (size LEN+4), oversize at the LEN byte, or TMO idle clocks pass.
  task automatic model_step(input logic dv, input logic [7:0] b);
    logic [7:0] x;
    exp_dv = 0; exp_err = 0;
    if (dv) begin
      idle = 0;
      if (fq.size() == 0) begin
        if (b == 8'hA5) fq.push_back(b);
      end else begin
        fq.push_back(b);
        if (fq.size() == 3 && int'(b) > ML) begin
          model_err(ERR_LEN);
        end else if (fq.size() >= 3 && fq.size() == int'(fq[2]) + 4) begin
          x = 0;
          for (int i = 1; i < fq.size() - 1; i++) x ^= fq[i];
          if (x == b) begin
            exp_dv  = 1;
            exp_cmd = fq[1];
            exp_len = fq[2];
            exp_pay = 0;
            for (int k = 0; k < int'(fq[2]); k++) exp_pay[8*k +: 8] = fq[3+k];
            fq.delete();
          end else begin
            model_err(ERR_CHK);
          end
        end
      end
    end else if (fq.size() != 0) begin
      idle++;
      if (idle == TMO) begin
        model_err(ERR_TMO);
        idle = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".cmd_dv"}, 64'(bus.o_Cmd_DV),  64'(exp_dv));
    chk({tag, ".err"},    64'(bus.o_Err),     64'(exp_err));
    chk({tag, ".code"},   64'(bus.o_Err_Code), 64'(exp_code));
    chk({tag, ".cmd"},    64'(bus.o_Cmd),     64'(exp_cmd));
    chk({tag, ".len"},    64'(bus.o_Len),     64'(exp_len));
    chk({tag, ".pay"},    bus.o_Payload,      exp_pay);
    chk({tag, ".busy"},   64'(bus.o_Busy),    64'(fq.size() != 0));
    if (bus.o_Cmd_DV) seen_dv  = 1;
    if (bus.o_Err)    seen_err = 1;
  endtask

  // Called at a negedge; drives one clock of input and checks the result.
  task automatic cycle(input logic dv, input logic [7:0] b);
    bus.i_Rx_DV   = dv;
    bus.i_Rx_Byte = dv ? b : 8'h00;
    @(negedge clk);
    model_step(dv, b);
    compare_all("cyc");
  endtask

  task automatic send_byte(input logic [7:0] b);
    cycle(1'b1, b);
    cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_Rx_DV = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          n;
    logic [95:0] bytes;   // last byte at [7:0]
    logic        exp_dv;
    logic        exp_err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [63:0] pay;
  } vec_t;

  vec_t        vt[7];
  logic [95:0] vb;
  logic [7:0]  fr[$];
  logic [7:0]  x;
  int          kind, len, n_send, gap;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{6,  96'hA51002334465,              1'b1, 1'b0, ERR_NONE, 8'h10, 8'h02, 64'h4433};
    vt[1] = '{4,  96'hA5070007,                  1'b1, 1'b0, ERR_NONE, 8'h07, 8'h00, 64'h0};
    vt[2] = '{5,  96'hA510015500,                1'b0, 1'b1, ERR_CHK,  8'h07, 8'h00, 64'h0};
    vt[3] = '{5,  96'hA50101AAAA,                1'b1, 1'b0, ERR_CHK,  8'h01, 8'h01, 64'hAA};
    vt[4] = '{3,  96'hA51009,                    1'b0, 1'b1, ERR_LEN,  8'h01, 8'h01, 64'hAA};
    vt[5] = '{6,  96'h1122A5200020,              1'b1, 1'b0, ERR_LEN,  8'h20, 8'h00, 64'h0};
    vt[6] = '{12, 96'hA53C0801A50304050607089B,  1'b1, 1'b0, ERR_LEN,  8'h3C, 8'h08, 64'h08070605_0403A501};

    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    seen_dv = 0; seen_err = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // Directed frame table.
    for (int i = 0; i < 7; i++) begin
      seen_dv = 0; seen_err = 0;
      vb = vt[i].bytes;
      for (int j = 0; j < vt[i].n; j++) send_byte(vb[8*(vt[i].n-1-j) +: 8]);
      chk($sformatf("vec%0d.dv_seen", i),  64'(seen_dv),        64'(vt[i].exp_dv));
      chk($sformatf("vec%0d.err_seen", i), 64'(seen_err),       64'(vt[i].exp_err));
      chk($sformatf("vec%0d.code", i),     64'(bus.o_Err_Code), 64'(vt[i].code));
      chk($sformatf("vec%0d.cmd", i),      64'(bus.o_Cmd),      64'(vt[i].cmd));
      chk($sformatf("vec%0d.len", i),      64'(bus.o_Len),      64'(vt[i].len));
      chk($sformatf("vec%0d.pay", i),      bus.o_Payload,       vt[i].pay);
    end

    // Stall after CMD: error on the TMO-th idle clock.
    seen_dv = 0; seen_err = 0;
    send_byte(8'hA5); send_byte(8'h10);
    repeat (TMO - 1) cycle(1'b0, 8'h00);
    chk("tmo.err_seen", 64'(seen_err),       64'd1);
    chk("tmo.code",     64'(bus.o_Err_Code), 64'(ERR_TMO));
    chk("tmo.busy",     64'(bus.o_Busy),     64'd0);

    // Byte lands exactly on the expiry clock: it wins.
    seen_dv = 0; seen_err = 0;
    send_byte(8'hA5); send_byte(8'h10);
    repeat (TMO - 2) cycle(1'b0, 8'h00);
    send_byte(8'h02); send_byte(8'h33); send_byte(8'h44); send_byte(8'h65);
    chk("tmo_edge.err_seen", 64'(seen_err),  64'd0);
    chk("tmo_edge.dv_seen",  64'(seen_dv),   64'd1);
    chk("tmo_edge.pay",      bus.o_Payload,  64'h4433);

    // Noise outside a frame.
    seen_dv = 0; seen_err = 0;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    chk("noise.dv_seen",  64'(seen_dv),  64'd0);
    chk("noise.err_seen", 64'(seen_err), 64'd0);
    chk("noise.busy",     64'(bus.o_Busy), 64'd0);

    // Reset mid-frame, then a fresh frame.
    seen_dv = 0; seen_err = 0;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33);
    do_reset();
    chk("rstmid.cmd",  64'(bus.o_Cmd),      64'd0);
    chk("rstmid.pay",  bus.o_Payload,       64'd0);
    chk("rstmid.code", 64'(bus.o_Err_Code), 64'd0);
    chk("rstmid.err_seen", 64'(seen_err),   64'd0);
    send_byte(8'hA5); send_byte(8'h22); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h79);
    chk("rstmid.dv_seen", 64'(seen_dv),  64'd1);
    chk("rstmid.cmd2",    64'(bus.o_Cmd), 64'h22);
    chk("rstmid.pay2",    bus.o_Payload,  64'h5A);

    // Random frames: good, bad checksum, oversize, noise, truncated.
    for (int f = 0; f < 150; f++) begin
      fr = {};
      kind = $urandom_range(0, 15);
      len  = (kind == 1) ? $urandom_range(ML + 1, 255) : $urandom_range(0, ML);
      fr.push_back(8'hA5);
      fr.push_back(8'($urandom));
      fr.push_back(8'(len));
      if (kind != 1) begin
        for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
        x = 0;
        for (int k = 1; k < fr.size(); k++) x ^= fr[k];
        if (kind == 2) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      if (kind == 0) fr = {8'($urandom)};
      n_send = fr.size();
      if (kind == 3) n_send = $urandom_range(1, fr.size() - 1);
      for (int j = 0; j < n_send; j++) begin
        cycle(1'b1, fr[j]);
        gap = ($urandom_range(0, 199) == 0) ? $urandom_range(TMO - 3, TMO + 1) : $urandom_range(1, 3);
        repeat (gap) cycle(1'b0, 8'h00);
      end
      if (kind == 3) repeat ($urandom_range(TMO - 2, TMO + 2)) cycle(1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
